dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256: number of 32-bit storage words.
REQ-002 Parameter LATENCY, default 2, legal range >=1: cycles from request acceptance to rsp_valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  1  initiator presents a request.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 Address  input  32  byte address.
REQ-008 DataWr  input  32  store data, right-aligned.
REQ-009 DMWr  input  1  1 = store, 0 = load.
REQ-010 DMCtrl  input  3  access size/sign, RISC-V funct3 encoding.
REQ-011 rsp_valid  output  1  response is available.
REQ-012 rsp_ready  input  1  initiator consumes the response.
REQ-013 DataRd  output  32  load result, extended per DMCtrl.
REQ-014 rsp_err  output  1  request was rejected; no state change.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP.
REQ-016 req_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-017 Acceptance: req_valid=1 and req_ready=1 at a rising edge; Address, DataWr, DMWr and DMCtrl are captured at that edge.
REQ-018 IDLE->WAIT on acceptance with counter loaded to LATENCY-1; if LATENCY=1, IDLE->RESP directly.
REQ-019 WAIT: counter decrements each cycle; WAIT->RESP when the counter reaches 0, so rsp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 RESP: rsp_valid=1, with DataRd and rsp_err held stable until rsp_ready=1; RESP->IDLE on the edge where rsp_valid=1 and rsp_ready=1.
REQ-021 Request inputs SHALL be ignored outside IDLE; there is no back-to-back acceptance in the response-handshake cycle.
REQ-022 Load encodings: 000 LB sign-extends byte, 001 LH sign-extends half, 010 LW, 100 LBU zero-extends byte, 101 LHU zero-extends half.
REQ-023 Store encodings: 000 SB, 001 SH, 010 SW; only the addressed bytes are written, other bytes of the word are preserved.
REQ-024 Byte order SHALL be little-endian; byte lane = Address[1:0]; word index = Address[31:2].
REQ-025 Stores commit on the WAIT->RESP (or IDLE->RESP) edge, never earlier.
REQ-026 rsp_err=1 SHALL be raised for: half access with Address[0]=1; word access with Address[1:0]!=0; word index >= DEPTH_WORDS; DMCtrl in {011,110,111}; store with DMCtrl in {100,101}.
REQ-027 On error, no memory write SHALL occur, DataRd=0, and LATENCY timing is unchanged.
REQ-028 On a store response, DataRd=0 and rsp_err=0 when the store is legal.
REQ-029 A load SHALL return data reflecting all previously responded stores (read-after-write ordering).
REQ-030 Memory contents are uninitialised at power-up and need not be reset.

Reset
REQ-031 While rst=1: state=IDLE, counter=0, rsp_valid=0, rsp_err=0, DataRd=0, req_ready=1 once rst deasserts.
REQ-032 Reset asserted in WAIT SHALL discard the pending request; a pending store is not written.
REQ-033 Reset SHALL NOT alter memory contents.

Verification
REQ-034 SW Address=0x10 DataWr=0xDEADBEEF, then LW 0x10 -> rsp_valid exactly 2 cycles after each acceptance; DataRd=0xDEADBEEF, rsp_err=0.
REQ-035 After REQ-034, SB 0x11 DataWr=0x55, then LB 0x11 -> 0x00000055; LW 0x10 -> 0xDEAD55EF; LBU 0x13 -> 0x000000DE; LB 0x13 -> 0xFFFFFFDE.
REQ-036 LH 0x12 -> 0xFFFFDEAD; LHU 0x12 -> 0x0000DEAD; LH 0x11 -> rsp_err=1, DataRd=0; SW 0x400 (DEPTH_WORDS=256) -> rsp_err=1, memory unchanged.
REQ-037 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, DataRd and rsp_err stable, req_ready=0, and a new req_valid is not accepted.
REQ-038 Accept SW 0x20 DataWr=0x12345678, assert rst one cycle later -> outputs return to reset values; LW 0x20 then returns the prior contents, not 0x12345678.
REQ-039 With LATENCY=1, accept LW -> rsp_valid=1 in the cycle after acceptance; with rsp_ready=1 tied high, req_ready returns to 1 the following cycle.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed LATENCY to response,
// RISC-V byte/half/word loads and stores with little-endian lanes.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] Address,
  input  logic [31:0] DataWr,
  input  logic        DMWr,
  input  logic [2:0]  DMCtrl,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] DataRd,
  output logic        rsp_err
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e         state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           wr_q, wr_d;
  logic [2:0]     ctrl_q, ctrl_d;
  logic [31:0]    rdata_q, rdata_d;
  logic           err_q, err_d;
  logic           commit;

  logic [31:0]    mem_q [DEPTH_WORDS];

  // Operands: live inputs when committing straight from IDLE (LATENCY=1),
  // otherwise the request captured at acceptance.
  logic [31:0]     op_addr, op_wdata;
  logic            op_wr;
  logic [2:0]      op_ctrl;
  logic [IdxW-1:0] idx;
  logic [31:0]     rd_word, load_data, wdata_sh;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [3:0]      be;
  logic            illegal, misalign, oob, op_err;

  assign op_addr  = (state_q == StIdle) ? Address : addr_q;
  assign op_wdata = (state_q == StIdle) ? DataWr  : wdata_q;
  assign op_wr    = (state_q == StIdle) ? DMWr    : wr_q;
  assign op_ctrl  = (state_q == StIdle) ? DMCtrl  : ctrl_q;

  assign idx      = op_addr[IdxW+1:2];
  assign rd_word  = mem_q[idx];
  assign byte_sel = rd_word[{op_addr[1:0], 3'b000} +: 8];
  assign half_sel = rd_word[{op_addr[1], 4'b0000} +: 16];
  assign wdata_sh = op_wdata << {op_addr[1:0], 3'b000};
  assign oob      = {2'b00, op_addr[31:2]} >= DEPTH_WORDS;
  assign op_err   = illegal | misalign | oob | (op_wr & op_ctrl[2]);

  // Decode access size: legality, alignment, load extension and byte enables.
  always_comb begin
    illegal   = 1'b0;
    misalign  = 1'b0;
    load_data = 32'h0;
    be        = 4'b0000;
    case (op_ctrl)
      3'b000: load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100: load_data = {24'h0, byte_sel};
      3'b001: begin
        misalign  = op_addr[0];
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      3'b101: begin
        misalign  = op_addr[0];
        load_data = {16'h0, half_sel};
      end
      3'b010: begin
        misalign  = |op_addr[1:0];
        load_data = rd_word;
      end
      default: illegal = 1'b1;
    endcase
    case (op_ctrl[1:0])
      2'b00:   be = 4'b0001 << op_addr[1:0];
      2'b01:   be = 4'b0011 << {op_addr[1], 1'b0};
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Next-state, request capture and response formation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = Address;
          wdata_d = DataWr;
          wr_d    = DMWr;
          ctrl_d  = DMCtrl;
          if (LATENCY == 1) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q <= CntW'(1)) begin
          state_d = StResp;
          commit  = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (commit) begin
      rdata_d = (op_err || op_wr) ? 32'h0 : load_data;
      err_d   = op_err;
    end
  end

  // Control and response registers; reset drops any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wr_q    <= 1'b0;
      ctrl_q  <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage array: no reset; legal stores commit only on the edge into RESP.
  always_ff @(posedge clk) begin
    if (commit && op_wr && !op_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign DataRd    = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-level memory model plus directed vectors.
module tb_dmem_responder;

  localparam int unsigned Lat   = 2;
  localparam int unsigned Depth = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] Address = 32'h0;
  logic [31:0] DataWr = 32'h0;
  logic        DMWr = 1'b0;
  logic [2:0]  DMCtrl = 3'b000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] DataRd;
  logic        rsp_err;

  // Second instance with LATENCY=1 and rsp_ready tied high.
  logic        req_valid1 = 1'b0;
  logic        req_ready1;
  logic [31:0] Address1 = 32'h0;
  logic [31:0] DataWr1 = 32'h0;
  logic        DMWr1 = 1'b0;
  logic [2:0]  DMCtrl1 = 3'b010;
  logic        rsp_valid1;
  logic        rsp_ready1;
  logic [31:0] DataRd1;
  logic        rsp_err1;
  assign rsp_ready1 = 1'b1;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(Depth), .LATENCY(Lat)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .DataRd(DataRd), .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(Depth), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .Address(Address1), .DataWr(DataWr1), .DMWr(DMWr1), .DMCtrl(DMCtrl1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .DataRd(DataRd1), .rsp_err(rsp_err1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0]  mem_b [Depth*4];
  logic        m_busy = 1'b0;
  int          m_age = 0;
  logic [31:0] m_addr, m_wdata, m_data;
  logic        m_wr, m_err;
  logic [2:0]  m_ctrl;

  // Apply one transaction to the byte memory and form its response.
  task automatic resolve();
    int size;
    logic [31:0] v;
    size = (m_ctrl[1:0] == 2'd1) ? 2 : (m_ctrl[1:0] == 2'd2) ? 4 : 1;
    m_err = (m_ctrl == 3'd3) || (m_ctrl == 3'd6) || (m_ctrl == 3'd7) ||
            (m_wr && m_ctrl[2]) || ((m_addr % size) != 0) || ((m_addr / 4) >= Depth);
    m_data = 32'h0;
    if (!m_err) begin
      if (m_wr) begin
        for (int i = 0; i < size; i++) mem_b[int'(m_addr) + i] = m_wdata[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_b[int'(m_addr) + i]) << (8 * i));
        if (!m_ctrl[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        m_data = v;
      end
    end
  endtask

  // Model timeline: a request is busy from acceptance until its response handshake;
  // the response (and any store) lands Lat cycles after the acceptance cycle.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (m_age >= Lat) begin
        if (rsp_ready) m_busy = 1'b0;
      end else begin
        m_age++;
        if (m_age == Lat) resolve();
      end
    end else if (req_valid) begin
      m_busy  = 1'b1;
      m_age   = 1;
      m_addr  = Address;
      m_wdata = DataWr;
      m_wr    = DMWr;
      m_ctrl  = DMCtrl;
      if (Lat == 1) resolve();
    end
  end

  // Compare process: every falling edge, outputs against the model.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      check("rst_rsp_err", 32'(rsp_err), 32'h0);
      check("rst_DataRd", DataRd, 32'h0);
    end else begin
      check("req_ready", 32'(req_ready), 32'(!m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= Lat));
      if (m_busy && m_age >= Lat) begin
        check("rsp_err", 32'(rsp_err), 32'(m_err));
        check("DataRd", DataRd, m_data);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input logic [31:0] addr, input logic wr, input logic [2:0] ctrl,
                      input logic [31:0] wdata, input int hold,
                      input logic [31:0] exp_d, input logic exp_e);
    int n;
    logic [31:0] first;
    @(negedge clk);
    req_valid = 1'b1;
    Address   = addr;
    DMWr      = wr;
    DMCtrl    = ctrl;
    DataWr    = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", 32'(n), 32'(Lat));
    check("lit_DataRd", DataRd, exp_d);
    check("lit_rsp_err", 32'(rsp_err), 32'(exp_e));
    first = DataRd;
    if (hold > 0) begin
      // A stray store to 0x10 that must not be accepted while the response waits.
      req_valid = 1'b1;
      Address   = 32'h10;
      DMWr      = 1'b1;
      DMCtrl    = 3'b010;
      DataWr    = 32'hBAD0_BAD0;
      repeat (hold) @(negedge clk);
      check("hold_req_ready", 32'(req_ready), 32'h0);
      check("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      check("hold_DataRd", DataRd, first);
      req_valid = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic send1(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                       input logic [31:0] exp_d);
    @(negedge clk);
    req_valid1 = 1'b1;
    Address1   = addr;
    DMWr1      = wr;
    DataWr1    = wdata;
    @(negedge clk);
    req_valid1 = 1'b0;
    check("l1_rsp_valid", 32'(rsp_valid1), 32'h1);
    check("l1_req_ready_busy", 32'(req_ready1), 32'h0);
    check("l1_DataRd", DataRd1, exp_d);
    check("l1_rsp_err", 32'(rsp_err1), 32'h0);
    @(negedge clk);
    check("l1_rsp_valid_done", 32'(rsp_valid1), 32'h0);
    check("l1_req_ready_back", 32'(req_ready1), 32'h1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(32'h10, 1'b1, 3'b010, 32'hDEAD_BEEF, 0, 32'h0, 1'b0);
    send(32'h10, 1'b0, 3'b010, 32'h0,         0, 32'hDEAD_BEEF, 1'b0);
    send(32'h11, 1'b1, 3'b000, 32'h55,        0, 32'h0, 1'b0);
    send(32'h11, 1'b0, 3'b000, 32'h0,         0, 32'h0000_0055, 1'b0);
    send(32'h10, 1'b0, 3'b010, 32'h0,         0, 32'hDEAD_55EF, 1'b0);
    send(32'h13, 1'b0, 3'b100, 32'h0,         0, 32'h0000_00DE, 1'b0);
    send(32'h13, 1'b0, 3'b000, 32'h0,         0, 32'hFFFF_FFDE, 1'b0);
    send(32'h12, 1'b0, 3'b001, 32'h0,         0, 32'hFFFF_DEAD, 1'b0);
    send(32'h12, 1'b0, 3'b101, 32'h0,         0, 32'h0000_DEAD, 1'b0);
    send(32'h11, 1'b0, 3'b001, 32'h0,         0, 32'h0, 1'b1);
    send(32'h00, 1'b1, 3'b010, 32'hA5A5_A5A5, 0, 32'h0, 1'b0);
    send(32'h400, 1'b1, 3'b010, 32'hFFFF_FFFF, 0, 32'h0, 1'b1);
    send(32'h00, 1'b0, 3'b010, 32'h0,         0, 32'hA5A5_A5A5, 1'b0);
    send(32'h402, 1'b0, 3'b010, 32'h0,        0, 32'h0, 1'b1);
    send(32'h00, 1'b0, 3'b011, 32'h0,         0, 32'h0, 1'b1);
    send(32'h00, 1'b1, 3'b100, 32'hFF,        0, 32'h0, 1'b1);
    send(32'h02, 1'b1, 3'b101, 32'hFFFF,      0, 32'h0, 1'b1);
    send(32'h00, 1'b0, 3'b110, 32'h0,         0, 32'h0, 1'b1);
    send(32'h00, 1'b0, 3'b111, 32'h0,         0, 32'h0, 1'b1);
    send(32'h00, 1'b0, 3'b010, 32'h0,         0, 32'hA5A5_A5A5, 1'b0);
    send(32'h10, 1'b0, 3'b010, 32'h0,         5, 32'hDEAD_55EF, 1'b0);
    send(32'h10, 1'b0, 3'b010, 32'h0,         0, 32'hDEAD_55EF, 1'b0);
    send(32'h02, 1'b1, 3'b001, 32'hBEEF,      0, 32'h0, 1'b0);
    send(32'h00, 1'b0, 3'b010, 32'h0,         0, 32'hBEEF_A5A5, 1'b0);
    send(32'h03, 1'b1, 3'b000, 32'h80,        0, 32'h0, 1'b0);
    send(32'h03, 1'b0, 3'b000, 32'h0,         0, 32'hFFFF_FF80, 1'b0);
    send(32'h02, 1'b0, 3'b101, 32'h0,         0, 32'h0000_80EF, 1'b0);
    send(32'h20, 1'b1, 3'b010, 32'hCAFE_F00D, 0, 32'h0, 1'b0);

    // Store accepted, then reset mid-flight: it must never land.
    @(negedge clk);
    req_valid = 1'b1;
    Address   = 32'h20;
    DMWr      = 1'b1;
    DMCtrl    = 3'b010;
    DataWr    = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_req_ready", 32'(req_ready), 32'h1);
    send(32'h20, 1'b0, 3'b010, 32'h0, 0, 32'hCAFE_F00D, 1'b0);

    send1(32'h04, 1'b1, 32'h1122_3344, 32'h0);
    send1(32'h04, 1'b0, 32'h0,         32'h1122_3344);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
